// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator between the MIPS execute stage and a word-addressed
//   data memory. One request per handshake, one response per request.
//   Loads extract a byte/halfword lane and sign/zero extend; sub-word stores
//   do a read-modify-write of the addressed word.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready == IDLE)
//   req_op, req_addr         MIPS opcode, byte address
//   req_wdata, req_rd        store data, load destination register
//   resp_valid/resp_ready    response handshake
//   resp_data, resp_rd       load result and destination (0 for stores/errors)
//   resp_err                 unsupported op, out-of-range or misaligned
//   mem_addr, mem_wdata      registered memory word address / write data
//   mem_we                   registered write enable, one cycle per write
//   mem_rdata                combinational memory read of mem_addr
//
// Configuration
//   MAU_ALIGN_CHECK_EN       defined: misaligned lh/lhu/sh/lw/sw are errors.
//                            undefined: the offending low address bits are
//                            ignored.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | mem_rdata valid; build load result or store word
// WRITE  | mem_we high, memory commits this cycle
// RESP   | response held until resp_ready

module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              mem_we_d;
  logic [31:0]       resp_data_d;
  logic [4:0]        resp_rd_d;
  logic              resp_err_d;

  logic        op_ok, op_load, range_bad, misalign, req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, store_word;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  always_comb begin
    op_ok   = 1'b0;
    op_load = 1'b0;
    case (req_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin op_ok = 1'b1; op_load = 1'b1; end
      OP_SB, OP_SH, OP_SW:                 op_ok = 1'b1;
      default: ;
    endcase
  end

  // Any address bit above the memory's byte range makes the request invalid.
  assign range_bad = (req_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef MAU_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
      OP_LW, OP_SW:         misalign = |req_addr[1:0];
      default: ;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = !op_ok || range_bad || misalign;

  assign byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (op_q)
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'd0, byte_sel};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word stores overwrite only their lane of the word just read.
  always_comb begin
    store_word = mem_rdata;
    case (op_q)
      OP_SB:   store_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      OP_SH:   store_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    resp_data_d = resp_data;
    resp_rd_d   = resp_rd;
    resp_err_d  = resp_err;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          rd_d    = req_rd;
          if (req_bad) begin
            resp_err_d  = 1'b1;
            resp_data_d = 32'd0;
            resp_rd_d   = 5'd0;
            state_d     = RESP;
          end else begin
            mem_addr_d = req_addr[ADDR_W+1:2];
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        resp_err_d = 1'b0;
        if (op_q[3] == 1'b0) begin
          // Load opcodes are 100xxx, stores 101xxx; only valid ops reach here.
          resp_data_d = load_val;
          resp_rd_d   = rd_q;
          state_d     = RESP;
        end else begin
          resp_data_d = 32'd0;
          resp_rd_d   = 5'd0;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_word;
          state_d     = WRITE;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          resp_data_d = 32'd0;
          resp_rd_d   = 5'd0;
          resp_err_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= 6'd0;
      lane_q    <= 2'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_we    <= 1'b0;
      resp_data <= 32'd0;
      resp_rd   <= 5'd0;
      resp_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      resp_data <= resp_data_d;
      resp_rd   <= resp_rd_d;
      resp_err  <= resp_err_d;
    end
  end

  // op_load is part of the decode but the FSM uses the opcode's store bit.
  logic unused_ok;
  assign unused_ok = op_load;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a behavioural word memory.
//   The memory commits writes on the falling edge while mem_we is high.

module tb_mem_access_unit;

  localparam int ADDR_W = 10;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [5:0]        req_op = '0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [4:0]        req_rd = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          we_count = 0;
  logic [31:0] we_addr  = '0;
  logic [31:0] we_data  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr];

  always @(negedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      we_count = we_count + 1;
      we_addr  = 32'(mem_addr);
      we_data  = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request; returns the number of rising edges from the
  // accepting edge until resp_valid is seen (capped at 8).
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       output int lat);
    check("req_ready_before", 32'(req_ready), 32'd1);
    req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic ack(input string tag);
    @(posedge CLK); #1;
    check(tag, 32'(resp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t lv [4];

  initial begin
    int lat;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;

    lv[0] = '{OP_LB,  32'h13, 5'd5, 32'hFFFF_FF80};
    lv[1] = '{OP_LBU, 32'h13, 5'd6, 32'h0000_0080};
    lv[2] = '{OP_LH,  32'h10, 5'd7, 32'h0000_7F01};
    lv[3] = '{OP_LHU, 32'h12, 5'd8, 32'h0000_80FF};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_resp_data",  resp_data,       32'd0);

    // sw 0x10 <- DEADBEEF
    we_count = 0;
    issue(OP_SW, 32'h10, 32'hDEAD_BEEF, 5'd3, lat);
    check("sw_latency",  32'(lat),      32'd3);
    check("sw_err",      32'(resp_err), 32'd0);
    check("sw_data",     resp_data,     32'd0);
    check("sw_rd",       32'(resp_rd),  32'd0);
    check("sw_we_count", 32'(we_count), 32'd1);
    check("sw_we_addr",  we_addr,       32'd4);
    check("sw_we_data",  we_data,       32'hDEAD_BEEF);
    check("sw_we_low",   32'(mem_we),   32'd0);
    ack("sw_resp_1cyc");

    // sub-word loads from 0x80FF7F01
    mem[4] = 32'h80FF_7F01;
    foreach (lv[i]) begin
      issue(lv[i].op, lv[i].addr, 32'd0, lv[i].rd, lat);
      check("ld_latency", 32'(lat),      32'd2);
      check("ld_data",    resp_data,     lv[i].exp);
      check("ld_rd",      32'(resp_rd),  32'(lv[i].rd));
      check("ld_err",     32'(resp_err), 32'd0);
      ack("ld_resp_1cyc");
    end

    // sb read-modify-write
    mem[4] = 32'h1122_3344;
    we_count = 0;
    issue(OP_SB, 32'h11, 32'h0000_00AB, 5'd2, lat);
    check("sb_latency",  32'(lat),      32'd3);
    check("sb_we_count", 32'(we_count), 32'd1);
    check("sb_mem",      mem[4],        32'h1122_AB44);
    check("sb_rd",       32'(resp_rd),  32'd0);
    ack("sb_resp_1cyc");

    // misaligned lw
    mem[0] = 32'hCAFE_F00D;
    we_count = 0;
    issue(OP_LW, 32'h2, 32'd0, 5'd4, lat);
`ifdef MAU_ALIGN_CHECK_EN
    check("mis_latency", 32'(lat),      32'd1);
    check("mis_err",     32'(resp_err), 32'd1);
    check("mis_data",    resp_data,     32'd0);
`else
    check("mis_latency", 32'(lat),      32'd2);
    check("mis_err",     32'(resp_err), 32'd0);
    check("mis_data",    resp_data,     32'hCAFE_F00D);
`endif
    check("mis_no_we", 32'(we_count), 32'd0);
    ack("mis_resp_1cyc");

    // range error
    issue(OP_LW, 32'h0000_1000, 32'd0, 5'd9, lat);
    check("range_latency", 32'(lat),      32'd1);
    check("range_err",     32'(resp_err), 32'd1);
    check("range_rd",      32'(resp_rd),  32'd0);
    ack("range_resp_1cyc");

    // opcode error
    issue(6'b000000, 32'h10, 32'd0, 5'd9, lat);
    check("op_latency", 32'(lat),      32'd1);
    check("op_err",     32'(resp_err), 32'd1);
    check("op_data",    resp_data,     32'd0);
    ack("op_resp_1cyc");

    // stall in RESP
    resp_ready = 1'b0;
    issue(OP_LW, 32'h10, 32'd0, 5'd9, lat);
    check("stall_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("stall_valid",     32'(resp_valid), 32'd1);
      check("stall_data",      resp_data,       32'h1122_AB44);
      check("stall_rd",        32'(resp_rd),    32'd9);
      check("stall_req_ready", 32'(req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    ack("stall_release");
    check("mem_addr_hold", 32'(mem_addr), 32'd4);

    // reset during WRITE of sh 0x16 <- BEEF
    mem[5] = 32'h1111_1111;
    we_count = 0;
    req_op = OP_SH; req_addr = 32'h16; req_wdata = 32'h0000_BEEF; req_rd = 5'd1;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check("sh_write_we",   32'(mem_we), 32'd1);
    check("sh_write_data", mem_wdata,   32'hBEEF_1111);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("mrst_mem_we",     32'(mem_we),     32'd0);
    check("mrst_mem_addr",   32'(mem_addr),   32'd0);
    check("mrst_mem_wdata",  mem_wdata,       32'd0);
    check("mrst_resp_valid", 32'(resp_valid), 32'd0);
    check("mrst_req_ready",  32'(req_ready),  32'd1);
    check("mrst_committed",  mem[5],          32'hBEEF_1111);
    check("mrst_we_count",   32'(we_count),   32'd1);

    // request during reset is ignored
    req_op = OP_LW; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("rstreq_resp_valid", 32'(resp_valid), 32'd0);
    check("rstreq_req_ready",  32'(req_ready),  32'd1);
    check("rstreq_mem_addr",   32'(mem_addr),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
